// File: rtl/bn_channel_engine_pkg.sv
// Shared helpers for layer engines: width derivation and round/saturate requantisation.
package bn_channel_engine_pkg;

    typedef struct packed {
        logic               sat;
        logic signed [63:0] val;
    } rnd_sat_t;

    function automatic int unsigned calc_ch_w(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned calc_acc_w(input int unsigned data_w,
                                               input int unsigned p_w,
                                               input int unsigned q_w);
        return ((data_w + p_w > q_w) ? data_w + p_w : q_w) + 1;
    endfunction

    // Round half up, arithmetic shift, then clamp to a signed out_w-bit range.
    function automatic rnd_sat_t round_sat(input logic signed [63:0] acc,
                                           input int unsigned        frac_shift,
                                           input int unsigned        out_w);
        rnd_sat_t           r;
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        v = acc;
        if (frac_shift > 0) begin
            v = (acc + (64'sd1 <<< (frac_shift - 1))) >>> frac_shift;
        end
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        r.sat = 1'b0;
        r.val = v;
        if (v > max_v) begin
            r.sat = 1'b1;
            r.val = max_v;
        end else if (v < min_v) begin
            r.sat = 1'b1;
            r.val = min_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/bn_channel_engine_coef_ram.sv
// Per-channel {p, q} coefficient store: single write port, registered read port.
module bn_coef_ram
    import bn_channel_engine_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 48
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // No reset so the array and read register map onto LUTRAM/BRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/bn_channel_engine.sv
// Streaming per-channel batch-norm: y = sat(round((x*p[ch] + q[ch]) >> FRAC_SHIFT)), opt. ReLU.
module bn_channel_engine
    import bn_channel_engine_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned COEF_P_W   = 16,
    parameter int unsigned COEF_Q_W   = 32,
    parameter int unsigned CHANNELS   = 16,
    parameter int unsigned FRAC_SHIFT = 8,
    localparam int unsigned CH_W      = calc_ch_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                relu_en,
    input  logic                clear,
    input  logic                coef_we,
    input  logic [CH_W-1:0]     coef_addr,
    input  logic [COEF_P_W-1:0] coef_p,
    input  logic [COEF_Q_W-1:0] coef_q,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [CH_W-1:0]     out_ch,
    output logic                out_last,
    output logic                sat_flag,
    output logic                frame_err
);

    localparam int unsigned    ACC_W   = calc_acc_w(DATA_W, COEF_P_W, COEF_Q_W);
    localparam int unsigned    RAM_W   = COEF_P_W + COEF_Q_W;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    logic stall;
    logic accept;

    logic [CH_W-1:0]          ch_cnt_d, ch_cnt_q;
    logic                     s1_valid_d, s1_valid_q;
    logic signed [DATA_W-1:0] s1_x_d, s1_x_q;
    logic [CH_W-1:0]          s1_ch_d, s1_ch_q;
    logic                     s1_last_d, s1_last_q;
    logic                     s2_valid_d, s2_valid_q;
    logic signed [ACC_W-1:0]  s2_acc_d, s2_acc_q;
    logic [CH_W-1:0]          s2_ch_d, s2_ch_q;
    logic                     s2_last_d, s2_last_q;
    logic                     out_valid_d, out_valid_q;
    logic [DATA_W-1:0]        out_data_d, out_data_q;
    logic [CH_W-1:0]          out_ch_d, out_ch_q;
    logic                     out_last_d, out_last_q;
    logic                     sat_flag_d, sat_flag_q;
    logic                     frame_err_d, frame_err_q;

    logic [RAM_W-1:0]           coef_rd;
    logic signed [COEF_P_W-1:0] coef_p_rd;
    logic signed [COEF_Q_W-1:0] coef_q_rd;
    logic signed [ACC_W-1:0]    mac;
    rnd_sat_t                   rs;
    logic [DATA_W-1:0]          res;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall && !coef_we;
    assign accept   = in_valid && in_ready;

    // Read is issued on acceptance so the coefficients line up with the sample in S1.
    bn_coef_ram #(
        .DEPTH  (CHANNELS),
        .ADDR_W (CH_W),
        .WIDTH  (RAM_W)
    ) u_coef_ram (
        .clk   (clk),
        .we    (coef_we),
        .waddr (coef_addr),
        .wdata ({coef_p, coef_q}),
        .re    (accept),
        .raddr (ch_cnt_q),
        .rdata (coef_rd)
    );

    assign coef_p_rd = coef_rd[RAM_W-1 -: COEF_P_W];
    assign coef_q_rd = coef_rd[COEF_Q_W-1:0];

    // Single A*B+C expression so S2 packs into one DSP slice.
    assign mac = ACC_W'(s1_x_q) * ACC_W'(coef_p_rd) + ACC_W'(coef_q_rd);

    always_comb begin
        rs  = round_sat(64'(s2_acc_q), FRAC_SHIFT, DATA_W);
        res = DATA_W'(rs.val);
        if (relu_en && res[DATA_W-1]) begin
            res = '0;
        end
    end

    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_ch_d     = s1_ch_q;
        s1_last_d   = s1_last_q;
        s2_valid_d  = s2_valid_q;
        s2_acc_d    = s2_acc_q;
        s2_ch_d     = s2_ch_q;
        s2_last_d   = s2_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        sat_flag_d  = sat_flag_q;
        frame_err_d = frame_err_q;

        if (accept) begin
            s1_x_d    = in_data;
            s1_ch_d   = ch_cnt_q;
            s1_last_d = in_last;
            ch_cnt_d  = (in_last || ch_cnt_q == LAST_CH) ? '0 : ch_cnt_q + CH_W'(1);
            if (in_last && ch_cnt_q != LAST_CH) begin
                frame_err_d = 1'b1;
            end
        end

        if (!stall) begin
            s1_valid_d  = accept;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (s1_valid_q) begin
                s2_acc_d  = mac;
                s2_ch_d   = s1_ch_q;
                s2_last_d = s1_last_q;
            end
            if (s2_valid_q) begin
                out_data_d = res;
                out_ch_d   = s2_ch_q;
                out_last_d = s2_last_q;
                if (rs.sat) begin
                    sat_flag_d = 1'b1;
                end
            end
        end

        if (clear) begin
            sat_flag_d  = 1'b0;
            frame_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_ch_q     <= '0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_acc_q    <= '0;
            s2_ch_q     <= '0;
            s2_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            sat_flag_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_ch_q     <= s1_ch_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_acc_q    <= s2_acc_d;
            s2_ch_q     <= s2_ch_d;
            s2_last_q   <= s2_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            sat_flag_q  <= sat_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_flag_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_bn_channel_engine.sv
// Randomised and directed bench for bn_channel_engine against a queue-based reference model.
module tb_bn_channel_engine;

    localparam int DW   = 16;
    localparam int CH   = 4;
    localparam int CHW  = 2;
    localparam int FRAC = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           relu_en = 1'b0;
    logic           clear = 1'b0;
    logic           coef_we = 1'b0;
    logic [CHW-1:0] coef_addr = '0;
    logic [15:0]    coef_p = '0;
    logic [31:0]    coef_q = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [DW-1:0]  in_data = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic [CHW-1:0] out_ch;
    logic           out_last;
    logic           sat_flag;
    logic           frame_err;

    bn_channel_engine #(
        .DATA_W     (DW),
        .COEF_P_W   (16),
        .COEF_Q_W   (32),
        .CHANNELS   (CH),
        .FRAC_SHIFT (FRAC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .relu_en   (relu_en),
        .clear     (clear),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_p    (coef_p),
        .coef_q    (coef_q),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .sat_flag  (sat_flag),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  data;
        logic [CHW-1:0] ch;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   m_p[CH];
    int   m_q[CH];
    int   m_ch = 0;
    bit   m_sat = 1'b0;
    bit   m_ferr = 1'b0;
    bit   prev_stall = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rnd_done;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, floor((acc + half) / 2^FRAC), clamp, then ReLU.
    function automatic exp_t model(input int x, input int ch, input bit last);
        longint acc;
        exp_t   e;
        acc = longint'(x) * longint'(m_p[ch]) + longint'(m_q[ch]);
        if (FRAC > 0) acc = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (acc > 32767) begin
            acc   = 32767;
            m_sat = 1'b1;
        end else if (acc < -32768) begin
            acc   = -32768;
            m_sat = 1'b1;
        end
        if (relu_en && acc < 0) acc = 0;
        e.data = 16'(acc);
        e.ch   = 2'(ch);
        e.last = last;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            m_ch       = 0;
            m_sat      = 1'b0;
            m_ferr     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", $signed(out_data), $signed(held.data));
                check_eq("hold_ch", out_ch, held.ch);
                check_eq("hold_last", out_last, held.last);
            end
            check_eq("in_ready", in_ready, !(out_valid && !out_ready) && !coef_we);
            if (coef_we) begin
                m_p[coef_addr] = int'($signed(coef_p));
                m_q[coef_addr] = int'($signed(coef_q));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", $signed(out_data), $signed(e.data));
                    check_eq("out_ch", out_ch, e.ch);
                    check_eq("out_last", out_last, e.last);
                end
            end
            if (in_valid && in_ready) begin
                if (in_last && m_ch != CH - 1) m_ferr = 1'b1;
                exp_q.push_back(model(int'($signed(in_data)), m_ch, in_last));
                m_ch = (in_last || m_ch == CH - 1) ? 0 : m_ch + 1;
            end
            if (clear) begin
                m_sat  = 1'b0;
                m_ferr = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            held.data  = out_data;
            held.ch    = out_ch;
            held.last  = out_last;
        end
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input int x, input bit last);
        in_valid = 1'b1;
        in_data  = 16'(x);
        in_last  = last;
        wait_accept();
    endtask

    task automatic write_coef(input int ch, input int p, input int q);
        coef_we   = 1'b1;
        coef_addr = 2'(ch);
        coef_p    = 16'(p);
        coef_q    = 32'(q);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check_eq("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_ch", out_ch, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_sat_flag", sat_flag, 0);
        check_eq("rst_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        write_coef(0, 256, 0);
        write_coef(1, 384, 128);
        write_coef(2, -200, 5000);
        write_coef(3, 1000, -70000);

        // Basic and latency
        send(100, 1'b0);
        k = 1;
        @(negedge clk);
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("latency", k, 3);
        check_eq("basic_data", $signed(out_data), 100);
        check_eq("basic_ch", out_ch, 0);
        drain();
        send(100, 1'b0);
        send(7, 1'b0);
        send(-9, 1'b1);
        drain();
        check_eq("frame_ok", frame_err, 0);
        send(-1, 1'b0);
        send(3, 1'b0);
        send(4, 1'b0);
        send(5, 1'b1);
        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 2000)) - 1000, (i % 4) == 3);
        drain();
        check_eq("wrap_frame_ok", frame_err, 0);

        // Saturation, ReLU, clear
        for (int c = 0; c < CH; c++) write_coef(c, 32767, 0);
        send(32767, 1'b0);
        send(-32768, 1'b0);
        send(0, 1'b0);
        send(1, 1'b1);
        drain();
        check_eq("sat_set", sat_flag, 1);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check_eq("sat_cleared", sat_flag, 0);
        check_eq("ferr_cleared", frame_err, 0);
        for (int c = 0; c < CH; c++) write_coef(c, 256, 0);
        relu_en = 1'b1;
        send(-100, 1'b0);
        send(50, 1'b0);
        send(-32768, 1'b0);
        send(32767, 1'b1);
        drain();
        check_eq("relu_no_sat", sat_flag, 0);
        relu_en = 1'b0;

        // Back-pressure: out_ready low for cycles 4..9 of a 10-sample stream
        for (int c = 0; c < CH; c++) write_coef(c, int'($urandom_range(0, 1023)) - 512,
                                                int'($urandom_range(0, 200000)) - 100000);
        fork
            for (int i = 0; i < 10; i++) send(int'($urandom_range(0, 65535)) - 32768, m_ch == CH - 1);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Random stream with random back-pressure and idle gaps
        for (int c = 0; c < CH; c++) write_coef(c, int'($urandom_range(0, 65535)) - 32768,
                                                int'($urandom));
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(int'($urandom_range(0, 65535)) - 32768, m_ch == CH - 1);
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        drain();
        check_eq("sat_model", sat_flag, m_sat);
        check_eq("ferr_model", frame_err, m_ferr);

        // Coefficient update mid-stream
        for (int c = 0; c < CH; c++) write_coef(c, 256, 0);
        send(11, 1'b0);
        send(12, 1'b0);
        in_valid  = 1'b1;
        in_data   = 16'(13);
        in_last   = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 2'(0);
        coef_p    = 16'(512);
        coef_q    = 32'(0);
        @(negedge clk);
        check_eq("coef_we_blocks", in_ready, 0);
        @(posedge clk);
        #1 coef_we = 1'b0;
        wait_accept();
        for (int i = 0; i < 6; i++) send(int'($urandom_range(0, 200)) - 100, m_ch == CH - 1);
        drain();

        // Framing error
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        while (m_ch != 0) send(1, m_ch == CH - 1);
        send(5, 1'b0);
        send(6, 1'b1);
        send(7, 1'b0);
        drain();
        check_eq("frame_err_set", frame_err, 1);
        check_eq("next_ch_zero", out_ch, 0);

        // Reset with samples in flight
        send(21, 1'b0);
        send(22, 1'b0);
        send(23, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_data", out_data, 0);
        check_eq("mid_rst_ch", out_ch, 0);
        check_eq("mid_rst_last", out_last, 0);
        check_eq("mid_rst_ferr", frame_err, 0);
        check_eq("mid_rst_sat", sat_flag, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("no_stale_out", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(42, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
